bus_transfer_controller: RTL and testbench

- Initiator side of the shared tri-state register bus.
- Sequences one register-to-register (or immediate/capture) transfer per request by generating per-register ENABLE/RW strobes.
- Drives DATA itself for immediates and captures DATA for external reads.
- Sits between the control unit and the bank of bidirectional registers; it is the only block that asserts bus strobes.

---
 rtl/bus_transfer_controller_pkg.sv | 13 +
 rtl/bus_transfer_controller_strobe.sv | 26 ++
 rtl/bus_transfer_controller.sv | 103 ++++++++++
 tb/tb_bus_transfer_controller.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/bus_transfer_controller_pkg.sv
// bus_transfer_controller_pkg: shared state encoding and bus RW strobe levels.
package bus_transfer_controller_pkg;
  localparam int DEFAULT_BUS_WIDTH = 16;
  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ = 1'b0;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIVE = 3'd1,
    ST_LATCH = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_e;
endpackage

// File: rtl/bus_transfer_controller_strobe.sv
// bus_strobe_decoder: maps transfer state and latched selects to per-register ENABLE/RW.
module bus_strobe_decoder
  import bus_transfer_controller_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int SEL_WIDTH = 3
) (
  input  state_e               state_i,
  input  logic [SEL_WIDTH-1:0] src_sel_i,
  input  logic [SEL_WIDTH-1:0] dst_sel_i,
  input  logic                 src_ext_i,
  input  logic                 dst_ext_i,
  output logic [NUM_REGS-1:0]  reg_enable_o,
  output logic [NUM_REGS-1:0]  reg_rw_o
);
  logic src_on, dst_on;
  assign src_on = (state_i == ST_DRIVE || state_i == ST_LATCH) && !src_ext_i;
  assign dst_on = state_i == ST_LATCH && !dst_ext_i;
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    logic is_src, is_dst;
    assign is_src = src_on && src_sel_i == SEL_WIDTH'(i);
    assign is_dst = dst_on && dst_sel_i == SEL_WIDTH'(i);
    assign reg_enable_o[i] = is_src || is_dst;
    assign reg_rw_o[i] = is_dst ? RW_READ : RW_WRITE;
  end
endmodule

// File: rtl/bus_transfer_controller.sv
// bus_transfer_controller: sequences one source-drive / destination-load transfer per request
// on the shared tri-state register bus, with immediate drive and external capture.
module bus_transfer_controller
  import bus_transfer_controller_pkg::*;
#(
  parameter int BUS_WIDTH = DEFAULT_BUS_WIDTH,
  parameter int NUM_REGS = 8,
  parameter int SEL_WIDTH = 3,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_i,
  input  logic [SEL_WIDTH-1:0] src_sel_i,
  input  logic [SEL_WIDTH-1:0] dst_sel_i,
  input  logic                 src_ext_i,
  input  logic                 dst_ext_i,
  input  logic [BUS_WIDTH-1:0] imm_data_i,
  output logic [NUM_REGS-1:0]  reg_enable_o,
  output logic [NUM_REGS-1:0]  reg_rw_o,
  inout  wire  [BUS_WIDTH-1:0] data_io,
  output logic [BUS_WIDTH-1:0] capture_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o
);
  localparam logic [SEL_WIDTH:0] REG_LIMIT = (SEL_WIDTH+1)'(NUM_REGS);
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [SEL_WIDTH-1:0] src_sel_q, src_sel_d, dst_sel_q, dst_sel_d;
  logic src_ext_q, src_ext_d, dst_ext_q, dst_ext_d;
  logic [BUS_WIDTH-1:0] imm_q, imm_d, capture_q, capture_d;
  logic illegal;
  assign illegal = (!src_ext_i && !dst_ext_i && src_sel_i == dst_sel_i) ||
                   (!src_ext_i && {1'b0, src_sel_i} >= REG_LIMIT) ||
                   (!dst_ext_i && {1'b0, dst_sel_i} >= REG_LIMIT);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    src_sel_d = src_sel_q;
    dst_sel_d = dst_sel_q;
    src_ext_d = src_ext_q;
    dst_ext_d = dst_ext_q;
    imm_d = imm_q;
    capture_d = capture_q;
    case (state_q)
      ST_IDLE: if (req_i) begin
        src_sel_d = src_sel_i;
        dst_sel_d = dst_sel_i;
        src_ext_d = src_ext_i;
        dst_ext_d = dst_ext_i;
        imm_d = imm_data_i;
        cnt_d = 4'(SETTLE_CYCLES - 1);
        state_d = illegal ? ST_ERR : ST_DRIVE;
      end
      ST_DRIVE: begin
        state_d = cnt_q == 4'd0 ? ST_LATCH : ST_DRIVE;
        cnt_d = cnt_q == 4'd0 ? cnt_q : cnt_q - 4'd1;
      end
      ST_LATCH: begin
        state_d = ST_DONE;
        capture_d = dst_ext_q ? data_io : capture_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      src_sel_q <= '0;
      dst_sel_q <= '0;
      src_ext_q <= 1'b0;
      dst_ext_q <= 1'b0;
      imm_q <= '0;
      capture_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      src_sel_q <= src_sel_d;
      dst_sel_q <= dst_sel_d;
      src_ext_q <= src_ext_d;
      dst_ext_q <= dst_ext_d;
      imm_q <= imm_d;
      capture_q <= capture_d;
    end
  end
  // The immediate stays on the bus through LATCH so the destination loads a stable value.
  assign data_io = (src_ext_q && (state_q == ST_DRIVE || state_q == ST_LATCH)) ? imm_q : 'z;
  assign capture_o = capture_q;
  assign busy_o = state_q != ST_IDLE;
  assign done_o = state_q == ST_DONE;
  assign error_o = state_q == ST_ERR;
  bus_strobe_decoder #(.NUM_REGS(NUM_REGS), .SEL_WIDTH(SEL_WIDTH)) u_strobe (
    .state_i(state_q),
    .src_sel_i(src_sel_q),
    .dst_sel_i(dst_sel_q),
    .src_ext_i(src_ext_q),
    .dst_ext_i(dst_ext_q),
    .reg_enable_o(reg_enable_o),
    .reg_rw_o(reg_rw_o)
  );
endmodule

// File: tb/tb_bus_transfer_controller.sv
// tb_bus_transfer_controller: register bank on the shared bus plus a transaction-level model.
module tb_bus_transfer_controller;
  localparam int BW = 16, NR = 7, SW = 3, S = 1;
  logic clk = 1'b0, rst_n = 1'b0, req = 1'b0, src_ext = 1'b0, dst_ext = 1'b0;
  logic [SW-1:0] src_sel = '0, dst_sel = '0;
  logic [BW-1:0] imm = '0, capture;
  logic [NR-1:0] en, rw;
  wire [BW-1:0] data_bus;
  logic busy, done, error;
  logic [BW-1:0] bank [NR];
  logic bank_drv;
  logic [BW-1:0] bank_val;
  logic [BW-1:0] m_regs [NR];
  bit m_known [NR];
  logic [BW-1:0] m_cap;
  int tests = 0, fails = 0;
  typedef struct {
    int s;
    int d;
    bit se;
    bit de;
    logic [BW-1:0] imm;
    bit exp_err;
    logic [BW-1:0] exp_val;
  } vec_t;
  vec_t tbl [12];
  always #5 clk = ~clk;
  bus_transfer_controller #(.BUS_WIDTH(BW), .NUM_REGS(NR), .SEL_WIDTH(SW), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .src_sel_i(src_sel), .dst_sel_i(dst_sel),
    .src_ext_i(src_ext), .dst_ext_i(dst_ext), .imm_data_i(imm), .reg_enable_o(en),
    .reg_rw_o(rw), .data_io(data_bus), .capture_o(capture), .busy_o(busy),
    .done_o(done), .error_o(error)
  );
  always_comb begin
    bank_drv = 1'b0;
    bank_val = '0;
    for (int i = 0; i < NR; i++)
      if (en[i] && rw[i]) begin
        bank_drv = 1'b1;
        bank_val = bank[i];
      end
  end
  assign data_bus = bank_drv ? bank_val : 'z;
  always @(posedge clk)
    for (int i = 0; i < NR; i++)
      if (en[i] && !rw[i]) bank[i] <= data_bus;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic bit legal(input int s, input int d, input bit se, input bit de);
    return !((!se && !de && s == d) || (!se && s >= NR) || (!de && d >= NR));
  endfunction
  task automatic check_bank();
    for (int i = 0; i < NR; i++)
      if (m_known[i]) check($sformatf("reg%0d", i), bank[i], m_regs[i]);
    check("capture", capture, m_cap);
  endtask
  task automatic run_xfer(input int s, input int d, input bit se, input bit de,
                          input logic [BW-1:0] v, output bit got_err, output logic [BW-1:0] got_val);
    bit ok;
    int last;
    logic [NR-1:0] e_en, e_rw;
    logic [BW-1:0] val;
    ok = legal(s, d, se, de);
    last = ok ? S + 2 : 1;
    got_err = 1'b0;
    @(negedge clk);
    src_sel = SW'(s); dst_sel = SW'(d); src_ext = se; dst_ext = de; imm = v; req = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= last; n++) begin
      @(negedge clk);
      req = 1'b0;
      e_en = '0;
      e_rw = '1;
      if (ok && n <= S + 1 && !se) e_en[s] = 1'b1;
      if (ok && n == S + 1 && !de) begin
        e_en[d] = 1'b1;
        e_rw[d] = 1'b0;
      end
      check("enable", en, e_en);
      check("rw", rw, e_rw);
      check("busy", busy, 1);
      check("done", done, 32'(ok && n == S + 2));
      check("error", error, 32'(!ok));
      if (ok && n <= S + 1) check("data", data_bus, se ? v : m_regs[s]);
      if (error) got_err = 1'b1;
    end
    if (ok) begin
      val = se ? v : m_regs[s];
      if (de) m_cap = val;
      else begin
        m_regs[d] = val;
        m_known[d] = 1'b1;
      end
    end
    got_val = de ? capture : (d < NR ? bank[d] : '0);
    check_bank();
  endtask
  initial begin
    bit ge;
    logic [BW-1:0] gv;
    int s, d;
    bit se, de;
    m_cap = '0;
    repeat (2) @(negedge clk);
    check("rst_enable", en, 0);
    check("rst_rw", rw, {NR{1'b1}});
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_capture", capture, 0);
    rst_n = 1'b1;
    for (int i = 0; i < NR; i++) run_xfer(0, i, 1'b1, 1'b0, BW'(16'h1111 * (i + 1)), ge, gv);
    tbl[0]  = '{0, 2, 1'b1, 1'b0, 16'hBEEF, 1'b0, 16'hBEEF};
    tbl[1]  = '{0, 3, 1'b1, 1'b0, 16'h00FF, 1'b0, 16'h00FF};
    tbl[2]  = '{2, 5, 1'b0, 1'b0, 16'h0000, 1'b0, 16'hBEEF};
    tbl[3]  = '{7, 0, 1'b1, 1'b0, 16'h1234, 1'b0, 16'h1234};
    tbl[4]  = '{3, 0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h00FF};
    tbl[5]  = '{4, 4, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000};
    tbl[6]  = '{0, 0, 1'b1, 1'b1, 16'hA5A5, 1'b0, 16'hA5A5};
    tbl[7]  = '{5, 1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'hBEEF};
    tbl[8]  = '{7, 1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000};
    tbl[9]  = '{1, 7, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000};
    tbl[10] = '{0, 7, 1'b1, 1'b0, 16'h5555, 1'b1, 16'h0000};
    tbl[11] = '{6, 6, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h7777};
    for (int t = 0; t < 12; t++) begin
      run_xfer(tbl[t].s, tbl[t].d, tbl[t].se, tbl[t].de, tbl[t].imm, ge, gv);
      check($sformatf("tbl%0d_err", t), 32'(ge), 32'(tbl[t].exp_err));
      if (!tbl[t].exp_err) check($sformatf("tbl%0d_val", t), gv, tbl[t].exp_val);
    end
    // Reset asserted in the middle of the LATCH cycle of reg1 -> reg6.
    @(negedge clk);
    src_sel = 3'd1; dst_sel = 3'd6; src_ext = 1'b0; dst_ext = 1'b0; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_enable", en, 0);
    check("abort_rw", rw, {NR{1'b1}});
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_capture", capture, 0);
    m_cap = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_bank();
    // REQ held high: acceptances every S+3 cycles, in-flight input changes ignored.
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      if (k > 0) check($sformatf("b2b_done_k%0d", k), done, 32'(k % (S + 3) == S + 2));
      if (k < 12) begin
        src_ext = 1'b1; dst_ext = 1'b0; dst_sel = SW'(k % 6); src_sel = SW'((k + 1) % 7);
        imm = BW'(16'h1000 + k); req = 1'b1;
      end else req = 1'b0;
    end
    for (int k = 0; k < 12; k += S + 3) begin
      m_regs[k % 6] = BW'(16'h1000 + k);
      m_known[k % 6] = 1'b1;
    end
    check_bank();
    for (int r = 0; r < 40; r++) begin
      s = $urandom_range(0, 7);
      d = $urandom_range(0, 7);
      se = $urandom_range(0, 3) == 0;
      de = $urandom_range(0, 3) == 0;
      run_xfer(s, d, se, de, BW'($urandom), ge, gv);
      check("rand_err", 32'(ge), 32'(!legal(s, d, se, de)));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
